led_pulse_scheduler: RTL and testbench

- Shares one timed pulse generator (down-counter plus one-shot state) among CHANNELS requesters, each driving one LED.
- Requesters raise a level request carrying a pulse duration. The scheduler grants round-robin, drives that channel's LED for exactly the latched duration, then returns a one-cycle acknowledge.
- Sits between the top-level LED register and the per-effect logic that today instantiates one pulser per LED.

---
 rtl/led_sched_pkg.sv | 21 ++
 rtl/led_sched_rr_pick.sv | 33 +++
 rtl/led_pulse_scheduler.sv | 125 ++++++++++++
 tb/tb_led_pulse_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types, default sizing and helpers for the LED pulse scheduler.
// The optional inter-pulse gap is enabled by defining LED_SCHED_GAP_EN.
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        GAP    = 2'd3
    } sched_state_t;

    localparam int DEF_CHANNELS    = 6;
    localparam int DEF_COUNT_WIDTH = 32;
    localparam int DEF_GAP_CYCLES  = 1000;

    // A zero-length request still produces a one-cycle pulse.
    function automatic logic [63:0] dur_eff(input logic [63:0] d);
        return (d == 64'd0) ? 64'd1 : d;
    endfunction

endpackage

// File: rtl/led_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, wrapping.
module led_sched_rr_pick
    import led_sched_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic [CHANNELS-1:0]         req,
    input  logic [$clog2(CHANNELS)-1:0] pointer,
    output logic                        valid,
    output logic [$clog2(CHANNELS)-1:0] index
);

    localparam int IDXW = $clog2(CHANNELS);

    logic [IDXW:0] cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            // pointer + i is below 2*CHANNELS, so one subtraction wraps it
            cand = {1'b0, pointer} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(CHANNELS))
                cand = cand - (IDXW+1)'(CHANNELS);
            if (!valid && req[cand[IDXW-1:0]]) begin
                valid = 1'b1;
                index = cand[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/led_pulse_scheduler.sv
// One shared timed pulser serving CHANNELS LED requesters round-robin.
// Define LED_SCHED_GAP_EN to insert GAP_CYCLES blank cycles after every pulse.
module led_pulse_scheduler
    import led_sched_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [CHANNELS-1:0]             req,
    input  logic [CHANNELS*COUNT_WIDTH-1:0] duration,
    output logic [CHANNELS-1:0]             ack,
    output logic [CHANNELS-1:0]             led,
    output logic                            busy,
    output logic [$clog2(CHANNELS)-1:0]     owner
);

    localparam int IDXW = $clog2(CHANNELS);
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    if (CHANNELS < 2 || CHANNELS > 16 || COUNT_WIDTH < 1 || COUNT_WIDTH > 64 || GAP_CYCLES < 0) begin : g_bad_params
        $error("led_pulse_scheduler: parameter out of range");
    end

`ifdef LED_SCHED_GAP_EN
    localparam logic [COUNT_WIDTH-1:0] GAP_LAST = COUNT_WIDTH'(dur_eff(64'(GAP_CYCLES)) - 64'd1);
`endif

    sched_state_t           state;
    logic [COUNT_WIDTH-1:0] counter;
    logic [COUNT_WIDTH-1:0] dur_lat;
    logic [IDXW-1:0]        rr_ptr;
    logic [IDXW-1:0]        rr_next;
    logic                   pick_valid;
    logic [IDXW-1:0]        pick_idx;
    logic [COUNT_WIDTH-1:0] pick_dur;

    function automatic logic [CHANNELS-1:0] onehot(input logic [IDXW-1:0] i);
        return CHANNELS'(1) << i;
    endfunction

    led_sched_rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_pick (
        .req     (req),
        .pointer (rr_ptr),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    always_comb begin
        pick_dur = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (IDXW'(i) == pick_idx)
                pick_dur = duration[i*COUNT_WIDTH +: COUNT_WIDTH];
        end
    end

    assign rr_next = (owner == IDXW'(CHANNELS - 1)) ? '0 : owner + IDXW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            counter <= '0;
            dur_lat <= '0;
            rr_ptr  <= '0;
            owner   <= '0;
            led     <= '0;
            ack     <= '0;
            busy    <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner   <= pick_idx;
                        dur_lat <= COUNT_WIDTH'(dur_eff(64'(pick_dur)));
                        counter <= '0;
                        led     <= onehot(pick_idx);
                        busy    <= 1'b1;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Compare against the latched length so the counter never wraps
                    if (counter == dur_lat - ONE) begin
                        led   <= '0;
                        ack   <= onehot(owner);
                        state <= DONE;
                    end else begin
                        counter <= counter + ONE;
                    end
                end
                DONE: begin
                    rr_ptr <= rr_next;
`ifdef LED_SCHED_GAP_EN
                    counter <= '0;
                    state   <= GAP;
`else
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
`ifdef LED_SCHED_GAP_EN
                GAP: begin
                    if (counter == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        counter <= counter + ONE;
                    end
                end
`endif
                default: begin
                    led   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pulse_scheduler.sv
// Scoreboard bench for led_pulse_scheduler; define LED_SCHED_GAP_EN to cover the gap build.
module tb_led_pulse_scheduler;

    localparam int CH = 6;
    localparam int W  = 32;
    localparam int TB_GAP = 4;
`ifdef LED_SCHED_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic            clock;
    logic            reset_n;
    logic [CH-1:0]   req;
    logic [CH*W-1:0] duration;
    logic [CH-1:0]   ack;
    logic [CH-1:0]   led;
    logic            busy;
    logic [2:0]      owner;

    typedef struct {
        int ch;
        int dur;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         run = 0;
    logic [CH-1:0] last_led = '0;

    led_pulse_scheduler #(
        .CHANNELS    (CH),
        .COUNT_WIDTH (W),
        .GAP_CYCLES  (TB_GAP)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .duration (duration),
        .ack      (ack),
        .led      (led),
        .busy     (busy),
        .owner    (owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [CH-1:0] oh(input int c);
        return CH'(1) << c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_dur(input int c, input int d);
        duration[c*W +: W] = W'(d);
    endtask

    // One cycle: sample at the falling edge, check against the scoreboard head,
    // and release the request of any acked channel.
    task automatic tick();
        @(negedge clock);
        if (sb.size() == 0) begin
            if (led != '0 || ack != '0)
                chk("spurious", {ack, led}, 0);
        end else begin
            if (led != '0) begin
                chk("led_ch", led, oh(sb[0].ch));
                run++;
            end
            if (ack != '0) begin
                chk("ack_ch", ack, oh(sb[0].ch));
                chk("pulse_len", run, sb[0].dur);
                chk("ack_after_led", last_led, oh(sb[0].ch));
                chk("owner", owner, sb[0].ch);
                req = req & ~ack;
                void'(sb.pop_front());
                run = 0;
            end
        end
        last_led = led;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && (sb.size() != 0 || busy); i++)
            tick();
        chk("drain_done", (sb.size() != 0) || busy, 0);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        req      = '0;
        sb.delete();
        run      = 0;
        last_led = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = '0;
        duration = '0;
        repeat (3) tick();
        chk("rst_led", led, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        reset_n = 1'b1;
        tick();

        // Single request: led cycles 1..5, ack at 6
        set_dur(2, 5);
        req[2] = 1'b1;
        sb.push_back('{2, 5});
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("single_led", led[2], (k >= 1 && k <= 5));
            chk("single_ack", ack[2], (k == 6));
            chk("single_busy", busy, (k <= 6) || (GAP_EN && k <= 6 + TB_GAP));
            if (k <= 6)
                chk("single_owner", owner, 2);
        end
        drain(100);

        // Contention from a fresh pointer: 0,1,3 then 5,0
        do_reset();
        set_dur(0, 3);
        set_dur(1, 3);
        set_dur(3, 3);
        req = 6'b001011;
        sb.push_back('{0, 3});
        sb.push_back('{1, 3});
        sb.push_back('{3, 3});
        drain(200);
        set_dur(5, 3);
        req = 6'b100001;
        sb.push_back('{5, 3});
        sb.push_back('{0, 3});
        drain(200);

        // Zero duration behaves as one cycle
        set_dur(4, 0);
        req[4] = 1'b1;
        sb.push_back('{4, 1});
        drain(100);

        // Withdrawn request still completes its full pulse
        set_dur(3, 10);
        req[3] = 1'b1;
        sb.push_back('{3, 10});
        tick();
        tick();
        req[3] = 1'b0;
        drain(100);

        // Reset in the middle of a long pulse
        set_dur(1, 100);
        req[1] = 1'b1;
        sb.push_back('{1, 100});
        repeat (40) tick();
        chk("mid_led_before", led, oh(1));
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_led", led, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_owner", owner, 0);
        req = '0;
        sb.delete();
        run      = 0;
        last_led = '0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        chk("mid_idle_busy", busy, 0);
        // Pointer left at 4 would serve 5 first; after reset 0 goes first
        set_dur(0, 2);
        set_dur(5, 2);
        req = 6'b100001;
        sb.push_back('{0, 2});
        sb.push_back('{5, 2});
        drain(200);

        // Back-to-back pair with pointer at 0
        set_dur(0, 2);
        set_dur(1, 2);
        req = 6'b000011;
        sb.push_back('{0, 2});
        sb.push_back('{1, 2});
`ifdef LED_SCHED_GAP_EN
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk("gap_led", led, (k <= 2) ? oh(0) : (k >= 9 && k <= 10) ? oh(1) : '0);
            chk("gap_busy", busy, (k != 8));
        end
`endif
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
